// File: rtl/routing_stage_wormhole_mesh_if.sv
// Flit handshake bundle for the mesh routing stage: one input channel
// plus five per-direction output channels (err_o with ROUTE_BOUNDS_CHECK_EN).
interface routing_stage_wormhole_mesh_if #(
    parameter int DATA_WIDTH = 32
);
    logic                       valid_i;
    logic                       ready_o;
    logic [DATA_WIDTH-1:0]      data_i;
    logic                       last_i;
    logic [4:0]                 valid_o;
    logic [4:0]                 ready_i;
    logic [4:0][DATA_WIDTH-1:0] data_o;
    logic                       last_o;
`ifdef ROUTE_BOUNDS_CHECK_EN
    logic                       err_o;
`endif

    modport master (
        output valid_i,
        output data_i,
        output last_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  data_o,
`ifdef ROUTE_BOUNDS_CHECK_EN
        input  err_o,
`endif
        input  last_o
    );

    modport slave (
        input  valid_i,
        input  data_i,
        input  last_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output data_o,
`ifdef ROUTE_BOUNDS_CHECK_EN
        output err_o,
`endif
        output last_o
    );
endinterface

// File: rtl/routing_stage_wormhole_mesh.sv
// Wormhole XY/YX route-compute stage with a 2-entry skid output buffer.
// Optional ROUTE_BOUNDS_CHECK_EN forces off-mesh heads local and flags err_o.
module routing_stage_wormhole_mesh #(
    parameter int DATA_WIDTH   = 32,
    parameter int X_WIDTH      = 2,
    parameter int Y_WIDTH      = 2,
    parameter int SOURCE_X     = 1,
    parameter int SOURCE_Y     = 1,
    parameter int ROUTING_MODE = 0,
    parameter int MESH_X       = 4,
    parameter int MESH_Y       = 4
) (
    input logic                     clk_i,
    input logic                     rst_i,
    routing_stage_wormhole_mesh_if.slave bus
);

    localparam logic [0:0] ST_HEAD = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    localparam logic [X_WIDTH-1:0] SRC_X = X_WIDTH'(SOURCE_X);
    localparam logic [Y_WIDTH-1:0] SRC_Y = Y_WIDTH'(SOURCE_Y);

    logic [X_WIDTH-1:0] dest_x;
    logic [Y_WIDTH-1:0] dest_y;
    logic [2:0]         x_sel;
    logic [2:0]         y_sel;
    logic [2:0]         calc_sel;
    logic [2:0]         route_sel;
    logic [2:0]         in_sel;
    logic               head_oob;

    logic [0:0]            state_q, state_d;
    logic [2:0]            lock_sel_q, lock_sel_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic                  main_last_q, main_last_d;
    logic [2:0]            main_sel_q, main_sel_d;
    logic                  main_valid_q, main_valid_d;

    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  skid_last_q, skid_last_d;
    logic [2:0]            skid_sel_q, skid_sel_d;
    logic                  skid_valid_q, skid_valid_d;

    logic accept;
    logic drain;
    logic is_head;

    assign dest_x = bus.data_i[DATA_WIDTH-1 -: X_WIDTH];
    assign dest_y = bus.data_i[DATA_WIDTH-1-X_WIDTH -: Y_WIDTH];

    always_comb begin
        x_sel = 3'd0;
        y_sel = 3'd0;
        if (dest_x > SRC_X) begin
            x_sel = 3'd2;
        end else if (dest_x < SRC_X) begin
            x_sel = 3'd4;
        end
        if (dest_y > SRC_Y) begin
            y_sel = 3'd3;
        end else if (dest_y < SRC_Y) begin
            y_sel = 3'd1;
        end
        if (ROUTING_MODE == 0) begin
            calc_sel = (x_sel != 3'd0) ? x_sel : y_sel;
        end else begin
            calc_sel = (y_sel != 3'd0) ? y_sel : x_sel;
        end
    end

`ifdef ROUTE_BOUNDS_CHECK_EN
    assign head_oob = (32'(dest_x) >= 32'(MESH_X)) ||
                      (32'(dest_y) >= 32'(MESH_Y));
`else
    assign head_oob = 1'b0;

    // Mesh size only matters when bounds checking is built in.
    if (MESH_X < 1 || MESH_Y < 1) begin : g_mesh_unused
    end
`endif

    assign route_sel = head_oob ? 3'd0 : calc_sel;
    assign is_head   = (state_q == ST_HEAD);
    assign in_sel    = is_head ? route_sel : lock_sel_q;

    assign bus.ready_o = ~skid_valid_q & ~rst_i;
    assign accept      = bus.valid_i & bus.ready_o;
    assign drain       = main_valid_q & bus.ready_i[main_sel_q];

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        err_d      = 1'b0;
        if (accept) begin
            if (is_head) begin
                err_d = head_oob;
                if (!bus.last_i) begin
                    state_d    = ST_BODY;
                    lock_sel_d = route_sel;
                end
            end else if (bus.last_i) begin
                state_d = ST_HEAD;
            end
        end
    end

    always_comb begin
        main_data_d  = main_data_q;
        main_last_d  = main_last_q;
        main_sel_d   = main_sel_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_sel_d   = skid_sel_q;
        skid_valid_d = skid_valid_q;

        if (drain) begin
            main_data_d  = skid_data_q;
            main_last_d  = skid_last_q;
            main_sel_d   = skid_sel_q;
            main_valid_d = skid_valid_q;
            skid_valid_d = 1'b0;
        end

        // Accept implies skid empty, so main is free unless it is stalled.
        if (accept) begin
            if (!main_valid_q || drain) begin
                main_data_d  = bus.data_i;
                main_last_d  = bus.last_i;
                main_sel_d   = in_sel;
                main_valid_d = 1'b1;
            end else begin
                skid_data_d  = bus.data_i;
                skid_last_d  = bus.last_i;
                skid_sel_d   = in_sel;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_HEAD;
            lock_sel_q   <= 3'd0;
            err_q        <= 1'b0;
            main_data_q  <= '0;
            main_last_q  <= 1'b0;
            main_sel_q   <= 3'd0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_sel_q   <= 3'd0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_sel_q   <= lock_sel_d;
            err_q        <= err_d;
            main_data_q  <= main_data_d;
            main_last_q  <= main_last_d;
            main_sel_q   <= main_sel_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            skid_sel_q   <= skid_sel_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    always_comb begin
        bus.valid_o = main_valid_q ? 5'(5'b00001 << main_sel_q) : 5'b00000;
        bus.last_o  = main_last_q & main_valid_q;
        for (int i = 0; i < 5; i++) begin
            if (main_valid_q && (main_sel_q == 3'(i))) begin
                bus.data_o[i] = main_data_q;
            end else begin
                bus.data_o[i] = '0;
            end
        end
    end

`ifdef ROUTE_BOUNDS_CHECK_EN
    assign bus.err_o = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule
